// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared types for the multicycle main control FSM. It holds the state
//   enum, the default opcode encodings, the datapath mux/ALU encodings, the
//   one-hot opcode class, and the control word that each state decodes to.
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

  localparam int         DEF_OPCODE_W    = 8;
  localparam logic [7:0] DEF_OPCODE_MASK = 8'h3F;
  localparam logic [7:0] DEF_OP_RTYPE    = 8'h2D;
  localparam logic [7:0] DEF_OP_LW       = 8'h2E;
  localparam logic [7:0] DEF_OP_SW       = 8'h2F;
  localparam logic [7:0] DEF_OP_J        = 8'h30;
  localparam logic [7:0] DEF_OP_BEQ      = 8'h31;
  localparam logic [7:0] DEF_OP_BNE      = 8'h32;
  localparam logic [7:0] DEF_OP_ADDI     = 8'h33;

  // Encodings 14 and 15 are unused. The next-state logic sends them to S_TRAP.
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC, S_ALU_WB, S_ADDI_WB, S_BEQ, S_BNE, S_JUMP, S_TRAP
  } state_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10
  } pc_source_e;

  // This is the only part of the opcode class that is still needed after
  // DECODE. MEM_ADDR uses it to choose between LW, SW and ADDI.
  typedef enum logic [1:0] {MEM_CLS_NONE, MEM_CLS_LW, MEM_CLS_SW, MEM_CLS_ADDI} mem_cls_e;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic addi;
    logic beq;
    logic bne;
    logic j;
    logic illegal;
  } op_class_t;

  // ready_gated marks states where pc_write, ir_write and instr_done take
  // effect only in the cycle that mem_ready is high.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
    logic       instr_done;
    logic       illegal;
    logic       ready_gated;
  } ctrl_t;

  // Moore control word for each state. Every field that a state does not
  // name stays 0.
  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read    = 1'b1;
        c.ir_write    = 1'b1;
        c.pc_write    = 1'b1;
        c.alu_src_b   = SRCB_FOUR;
        c.ready_gated = 1'b1;
      end
      S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write   = 1'b1;
        c.i_or_d      = 1'b1;
        c.instr_done  = 1'b1;
        c.ready_gated = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dest   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        c.alu_src_a        = 1'b1;
        c.alu_op           = ALU_SUB;
        c.pc_source        = PCSRC_ALUOUT;
        c.pc_write_cond    = (s == S_BEQ);
        c.pc_write_cond_ne = (s == S_BNE);
        c.instr_done       = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//   Bus between the main control FSM and the multicycle datapath.
//   The datapath side drives:   opcode (from IR) and mem_ready.
//   The control side drives:    pc_write, pc_write_cond, pc_write_cond_ne,
//                               i_or_d, mem_read, mem_write, ir_write,
//                               mem_to_reg, reg_dest, reg_write, alu_src_a,
//                               alu_src_b, alu_op, pc_source, instr_done,
//                               illegal.
//   The master modport belongs to the controller. The slave modport belongs
//   to the datapath.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int OPCODE_W = 8
) ();
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                pc_write_cond_ne;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dest;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                instr_done;
  logic                illegal;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read,
           mem_write, ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, instr_done, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read,
           mem_write, ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_source, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_control_opcode_class_decoder.sv
// ---------------------------------------------------------------------------
// opcode_class_decoder
//   Combinational decoder that turns an opcode into a one-hot instruction
//   class. Opcode bits outside OPCODE_MASK are ignored. If no encoding
//   matches, the class is illegal.
//   Ports: opcode (in, OPCODE_W), op_class (out, op_class_t).
// ---------------------------------------------------------------------------
module opcode_class_decoder
  import multicycle_control_pkg::*;
#(
  parameter int                  OPCODE_W    = DEF_OPCODE_W,
  parameter logic [OPCODE_W-1:0] OPCODE_MASK = DEF_OPCODE_MASK,
  parameter logic [OPCODE_W-1:0] OP_RTYPE    = DEF_OP_RTYPE,
  parameter logic [OPCODE_W-1:0] OP_LW       = DEF_OP_LW,
  parameter logic [OPCODE_W-1:0] OP_SW       = DEF_OP_SW,
  parameter logic [OPCODE_W-1:0] OP_J        = DEF_OP_J,
  parameter logic [OPCODE_W-1:0] OP_BEQ      = DEF_OP_BEQ,
  parameter logic [OPCODE_W-1:0] OP_BNE      = DEF_OP_BNE,
  parameter logic [OPCODE_W-1:0] OP_ADDI     = DEF_OP_ADDI
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class
);

  logic [OPCODE_W-1:0] masked;

  assign masked = opcode & OPCODE_MASK;

  // The reference encodings are masked as well, so an encoding parameter may
  // carry don't-care upper bits.
  assign op_class.rtype   = (masked == (OP_RTYPE & OPCODE_MASK));
  assign op_class.lw      = (masked == (OP_LW    & OPCODE_MASK));
  assign op_class.sw      = (masked == (OP_SW    & OPCODE_MASK));
  assign op_class.addi    = (masked == (OP_ADDI  & OPCODE_MASK));
  assign op_class.beq     = (masked == (OP_BEQ   & OPCODE_MASK));
  assign op_class.bne     = (masked == (OP_BNE   & OPCODE_MASK));
  assign op_class.j       = (masked == (OP_J     & OPCODE_MASK));
  assign op_class.illegal = ~(op_class.rtype | op_class.lw | op_class.sw |
                              op_class.addi | op_class.beq | op_class.bne |
                              op_class.j);

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the multicycle Extended-MIPS core. For each
//   instruction it steps through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
//   It stalls on the memory ready handshake and traps on unknown opcodes.
//   Ports: clk    rising-edge clock
//          reset  asynchronous, active-high
//          bus    multicycle_control_if.master: opcode and mem_ready in,
//                 datapath control strobes and selects out
// ---------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int                  OPCODE_W    = DEF_OPCODE_W,
  parameter logic [OPCODE_W-1:0] OPCODE_MASK = DEF_OPCODE_MASK,
  parameter logic [OPCODE_W-1:0] OP_RTYPE    = DEF_OP_RTYPE,
  parameter logic [OPCODE_W-1:0] OP_LW       = DEF_OP_LW,
  parameter logic [OPCODE_W-1:0] OP_SW       = DEF_OP_SW,
  parameter logic [OPCODE_W-1:0] OP_J        = DEF_OP_J,
  parameter logic [OPCODE_W-1:0] OP_BEQ      = DEF_OP_BEQ,
  parameter logic [OPCODE_W-1:0] OP_BNE      = DEF_OP_BNE,
  parameter logic [OPCODE_W-1:0] OP_ADDI     = DEF_OP_ADDI
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_e    state;
  state_e    next_state;
  mem_cls_e  mem_cls;
  mem_cls_e  dec_mem_cls;
  ctrl_t     ctrl_q;
  op_class_t op_class;
  logic      ready_ok;

  opcode_class_decoder #(
    .OPCODE_W   (OPCODE_W),
    .OPCODE_MASK(OPCODE_MASK),
    .OP_RTYPE   (OP_RTYPE),
    .OP_LW      (OP_LW),
    .OP_SW      (OP_SW),
    .OP_J       (OP_J),
    .OP_BEQ     (OP_BEQ),
    .OP_BNE     (OP_BNE),
    .OP_ADDI    (OP_ADDI)
  ) u_opcode_class_decoder (
    .opcode  (bus.opcode),
    .op_class(op_class)
  );

  always_comb begin
    // NOTE: assign a default before any branch so that every path of a
    // combinational block drives every variable. Without it a latch is
    // inferred.
    dec_mem_cls = MEM_CLS_NONE;
    if (op_class.lw)        dec_mem_cls = MEM_CLS_LW;
    else if (op_class.sw)   dec_mem_cls = MEM_CLS_SW;
    else if (op_class.addi) dec_mem_cls = MEM_CLS_ADDI;
  end

  always_comb begin
    next_state = S_TRAP;
    case (state)
      S_RESET:  next_state = S_FETCH;
      S_FETCH:  next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_class.rtype)                                 next_state = S_EXEC;
        else if (op_class.lw | op_class.sw | op_class.addi) next_state = S_MEM_ADDR;
        else if (op_class.beq)                              next_state = S_BEQ;
        else if (op_class.bne)                              next_state = S_BNE;
        else if (op_class.j)                                next_state = S_JUMP;
        else                                                next_state = S_TRAP;
      end
      // Branch on the class latched in DECODE. The opcode is not read again,
      // because IR may already be changing.
      S_MEM_ADDR: begin
        case (mem_cls)
          MEM_CLS_LW:   next_state = S_MEM_RD;
          MEM_CLS_SW:   next_state = S_MEM_WR;
          MEM_CLS_ADDI: next_state = S_ADDI_WB;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEM_RD:  next_state = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  next_state = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:    next_state = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BEQ, S_BNE, S_JUMP: next_state = S_FETCH;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_TRAP;
    endcase
  end

  // The control word is registered from next_state, so the outputs come
  // straight from flops. An asynchronous reset clears them in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RESET;
      mem_cls <= MEM_CLS_NONE;
      ctrl_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment. Every flop then
      // samples the values from before the edge, whatever the statement order.
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state);
      if (state == S_DECODE) mem_cls <= dec_mem_cls;
    end
  end

  assign ready_ok = ~ctrl_q.ready_gated | bus.mem_ready;

  assign bus.pc_write         = ctrl_q.pc_write & ready_ok;
  assign bus.ir_write         = ctrl_q.ir_write & ready_ok;
  assign bus.instr_done       = ctrl_q.instr_done & ready_ok;
  assign bus.pc_write_cond    = ctrl_q.pc_write_cond;
  assign bus.pc_write_cond_ne = ctrl_q.pc_write_cond_ne;
  assign bus.i_or_d           = ctrl_q.i_or_d;
  assign bus.mem_read         = ctrl_q.mem_read;
  assign bus.mem_write        = ctrl_q.mem_write;
  assign bus.mem_to_reg       = ctrl_q.mem_to_reg;
  assign bus.reg_dest         = ctrl_q.reg_dest;
  assign bus.reg_write        = ctrl_q.reg_write;
  assign bus.alu_src_a        = ctrl_q.alu_src_a;
  assign bus.alu_src_b        = ctrl_q.alu_src_b;
  assign bus.alu_op           = ctrl_q.alu_op;
  assign bus.pc_source        = ctrl_q.pc_source;
  assign bus.illegal          = ctrl_q.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for the multicycle control FSM. Each cycle it drives
//   opcode and mem_ready, then compares the full 19-bit control vector with
//   a hand-built constant for the state expected at that point.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multicycle_control_if #(.OPCODE_W(8)) bus ();

  multicycle_control dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Bit map of the observed control vector.
  localparam logic [18:0] B_PCW      = 19'h1 << 18;
  localparam logic [18:0] B_PCC      = 19'h1 << 17;
  localparam logic [18:0] B_PCNE     = 19'h1 << 16;
  localparam logic [18:0] B_IORD     = 19'h1 << 15;
  localparam logic [18:0] B_MRD      = 19'h1 << 14;
  localparam logic [18:0] B_MWR      = 19'h1 << 13;
  localparam logic [18:0] B_IRW      = 19'h1 << 12;
  localparam logic [18:0] B_M2R      = 19'h1 << 11;
  localparam logic [18:0] B_RDST     = 19'h1 << 10;
  localparam logic [18:0] B_RW       = 19'h1 << 9;
  localparam logic [18:0] B_SRCA     = 19'h1 << 8;
  localparam logic [18:0] B_SRCB_4   = 19'h1 << 6;
  localparam logic [18:0] B_SRCB_IMM = 19'h2 << 6;
  localparam logic [18:0] B_SRCB_SH  = 19'h3 << 6;
  localparam logic [18:0] B_OP_SUB   = 19'h1 << 4;
  localparam logic [18:0] B_OP_FN    = 19'h2 << 4;
  localparam logic [18:0] B_PCS_OUT  = 19'h1 << 2;
  localparam logic [18:0] B_PCS_J    = 19'h2 << 2;
  localparam logic [18:0] B_DONE     = 19'h1 << 1;
  localparam logic [18:0] B_ILL      = 19'h1;

  localparam logic [18:0] E_FETCH    = B_PCW | B_MRD | B_IRW | B_SRCB_4;
  localparam logic [18:0] E_FETCH_ST = B_MRD | B_SRCB_4;
  localparam logic [18:0] E_DECODE   = B_SRCB_SH;
  localparam logic [18:0] E_MEM_ADDR = B_SRCA | B_SRCB_IMM;
  localparam logic [18:0] E_MEM_RD   = B_MRD | B_IORD;
  localparam logic [18:0] E_MEM_WB   = B_RW | B_M2R | B_DONE;
  localparam logic [18:0] E_MEM_WR   = B_MWR | B_IORD | B_DONE;
  localparam logic [18:0] E_MEM_WR_S = B_MWR | B_IORD;
  localparam logic [18:0] E_EXEC     = B_SRCA | B_OP_FN;
  localparam logic [18:0] E_ALU_WB   = B_RW | B_RDST | B_DONE;
  localparam logic [18:0] E_ADDI_WB  = B_RW | B_DONE;
  localparam logic [18:0] E_BEQ      = B_SRCA | B_OP_SUB | B_PCS_OUT | B_PCC | B_DONE;
  localparam logic [18:0] E_BNE      = B_SRCA | B_OP_SUB | B_PCS_OUT | B_PCNE | B_DONE;
  localparam logic [18:0] E_JUMP     = B_PCW | B_PCS_J | B_DONE;
  localparam logic [18:0] E_TRAP     = B_ILL;

  logic [18:0] obs;
  assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_write_cond_ne, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                bus.reg_dest, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Enter at posedge+1. Drive the inputs, compare at posedge+2, then move on
  // to the next posedge+1.
  task automatic cyc(input logic [7:0] op, input logic rdy, input logic [18:0] exp,
                     input string tag);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    #1;
    check(tag, {13'b0, obs}, {13'b0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [5:0] legal [7] = '{6'h2D, 6'h2E, 6'h2F, 6'h30, 6'h31, 6'h32, 6'h33};

  initial begin
    int n_irw;
    int n_done;
    int viol;
    logic [1:0] hi;

    reset         = 1'b1;
    bus.opcode    = 8'h00;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {13'b0, obs}, 32'h0);
    reset = 1'b0;
    #1;
    check("after_release", {13'b0, obs}, 32'h0);
    @(posedge clk);
    #1;

    // R-type, 4 cycles
    cyc(8'h2D, 1'b1, E_FETCH,  "r_fetch");
    cyc(8'h2D, 1'b1, E_DECODE, "r_decode");
    cyc(8'h00, 1'b1, E_EXEC,   "r_exec");
    cyc(8'h00, 1'b1, E_ALU_WB, "r_alu_wb");

    // LW with a 3-cycle stall in MEM_RD. The opcode changes after DECODE and
    // must be ignored.
    cyc(8'h2E, 1'b1, E_FETCH,    "lw_fetch");
    cyc(8'h2E, 1'b1, E_DECODE,   "lw_decode");
    cyc(8'h2F, 1'b0, E_MEM_ADDR, "lw_mem_addr");
    for (int i = 0; i < 3; i++) cyc(8'h2F, 1'b0, E_MEM_RD, "lw_mem_rd_stall");
    cyc(8'h2F, 1'b1, E_MEM_RD, "lw_mem_rd_ready");
    cyc(8'h2F, 1'b0, E_MEM_WB, "lw_mem_wb");

    // SW with a fetch stall and a write stall
    cyc(8'h2F, 1'b0, E_FETCH_ST, "sw_fetch_stall");
    cyc(8'h2F, 1'b1, E_FETCH,    "sw_fetch");
    cyc(8'h2F, 1'b1, E_DECODE,   "sw_decode");
    cyc(8'h2E, 1'b1, E_MEM_ADDR, "sw_mem_addr");
    cyc(8'h2E, 1'b0, E_MEM_WR_S, "sw_mem_wr_stall");
    cyc(8'h2E, 1'b1, E_MEM_WR,   "sw_mem_wr_ready");

    // ADDI, BEQ, BNE, J
    cyc(8'h33, 1'b1, E_FETCH,    "addi_fetch");
    cyc(8'h33, 1'b1, E_DECODE,   "addi_decode");
    cyc(8'h33, 1'b1, E_MEM_ADDR, "addi_mem_addr");
    cyc(8'h33, 1'b1, E_ADDI_WB,  "addi_wb");
    cyc(8'h31, 1'b1, E_FETCH,    "beq_fetch");
    cyc(8'h31, 1'b1, E_DECODE,   "beq_decode");
    cyc(8'h31, 1'b1, E_BEQ,      "beq_exec");
    cyc(8'h32, 1'b1, E_FETCH,    "bne_fetch");
    cyc(8'h32, 1'b1, E_DECODE,   "bne_decode");
    cyc(8'h32, 1'b1, E_BNE,      "bne_exec");
    cyc(8'h30, 1'b1, E_FETCH,    "j_fetch");
    cyc(8'h30, 1'b1, E_DECODE,   "j_decode");
    cyc(8'h30, 1'b1, E_JUMP,     "j_exec");

    // Masked opcode 0xAD behaves as R-type
    cyc(8'hAD, 1'b1, E_FETCH,  "mask_fetch");
    cyc(8'hAD, 1'b1, E_DECODE, "mask_decode");
    cyc(8'hAD, 1'b1, E_EXEC,   "mask_exec");
    cyc(8'hAD, 1'b1, E_ALU_WB, "mask_alu_wb");

    // Unknown opcode traps, and the trap persists
    cyc(8'h34, 1'b1, E_FETCH,  "trap_fetch");
    cyc(8'h34, 1'b1, E_DECODE, "trap_decode");
    for (int i = 0; i < 10; i++)
      cyc(8'($urandom), 1'($urandom_range(0, 1)), E_TRAP, "trap_hold");
    reset = 1'b1;
    #1;
    check("trap_reset_clears", {13'b0, obs}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset asserted in the middle of a store
    cyc(8'h2F, 1'b1, E_FETCH,    "rst_sw_fetch");
    cyc(8'h2F, 1'b1, E_DECODE,   "rst_sw_decode");
    cyc(8'h2F, 1'b1, E_MEM_ADDR, "rst_sw_mem_addr");
    bus.mem_ready = 1'b0;
    #1;
    check("rst_sw_mem_wr", {13'b0, obs}, {13'b0, E_MEM_WR_S});
    reset = 1'b1;
    #1;
    check("rst_async_clear", {13'b0, obs}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_released_idle", {13'b0, obs}, 32'h0);
    @(posedge clk);
    #1;
    cyc(8'h2D, 1'b1, E_FETCH, "rst_then_fetch");

    // Random legal stream: a fetch completes (ir_write) once per
    // instruction, and instr_done must pulse once per instruction as well.
    n_irw  = 0;
    n_done = 0;
    viol   = 0;
    cyc(8'h2D, 1'b1, E_DECODE, "rand_start_decode");
    cyc(8'h2D, 1'b1, E_EXEC,   "rand_start_exec");
    cyc(8'h2D, 1'b1, E_ALU_WB, "rand_start_wb");
    for (int i = 0; i < 400; i++) begin
      hi            = 2'($urandom);
      bus.opcode    = {hi, legal[$urandom_range(0, 6)]};
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.mem_read && bus.mem_write) viol++;
      if (bus.ir_write) n_irw++;
      if (bus.instr_done) n_done++;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (n_irw == n_done) break;
      #1;
      if (bus.mem_read && bus.mem_write) viol++;
      if (bus.ir_write) n_irw++;
      if (bus.instr_done) n_done++;
      @(posedge clk);
      #1;
    end
    check("rand_no_rd_wr_overlap", viol, 0);
    check("rand_done_count", n_done, n_irw);
    check("rand_done_nonzero", (n_done > 10) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
